// File: rtl/vpe_fea_feeder_if.sv
// Feature-feeder bus: parser word stream in, controller fetch handshake and status out.
// slave = feeder side, master = parser/controller side.
interface vpe_fea_feeder_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 16,
    parameter int DEPTH     = 4
);
    logic                          s_valid;
    logic                          s_ready;
    logic [DATA_W-1:0]             s_data;
    logic                          s_last;
    logic                          fetch_pkt_fea;
    logic                          pkt_fea_valid;
    logic [NUM_WORDS*DATA_W-1:0]   pkt_fea;
    logic                          fea_err;
    logic [15:0]                   drop_cnt;
    logic [$clog2(DEPTH):0]        fifo_level;

    modport slave (
        input  s_valid, s_data, s_last, fetch_pkt_fea,
        output s_ready, pkt_fea_valid, pkt_fea, fea_err, drop_cnt, fifo_level
    );

    modport master (
        output s_valid, s_data, s_last, fetch_pkt_fea,
        input  s_ready, pkt_fea_valid, pkt_fea, fea_err, drop_cnt, fifo_level
    );
endinterface

// File: rtl/vpe_fea_feeder.sv
// Assembles parser feature words into NUM_WORDS-wide vectors, buffers them, serves one per fetch.
// Optional FEA_DROP_CNT_EN: saturating count of malformed (short/long) packets on drop_cnt.
module vpe_fea_feeder #(
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = 16,
    parameter int DEPTH     = 4
) (
    input  logic               clk,
    input  logic               rst,
    vpe_fea_feeder_if.slave    bus
);
    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESENT  = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW = 2'd2;

    logic [CW-1:0]                        r_word_cnt;
    logic                                 r_drop;
    logic [NUM_WORDS-1:0][DATA_W-1:0]     r_asm;
    logic [NUM_WORDS-1:0][DATA_W-1:0]     r_mem [DEPTH];
    logic [PW-1:0]                        r_wptr;
    logic [PW-1:0]                        r_rptr;
    logic [1:0]                           r_state;
    logic [NUM_WORDS-1:0][DATA_W-1:0]     r_pkt_fea;
    logic                                 r_err;

    logic [PW-1:0]                        w_level;
    logic                                 w_full;
    logic                                 w_at_end;
    logic                                 w_commit_word;
    logic                                 w_ready;
    logic                                 w_acc;
    logic                                 w_push;
    logic                                 w_short;
    logic                                 w_long;
    logic                                 w_pop;
    logic [NUM_WORDS-1:0][DATA_W-1:0]     w_push_vec;

    assign w_level       = r_wptr - r_rptr;
    assign w_full        = (w_level == PW'(DEPTH));
    assign w_at_end      = (r_word_cnt == LAST_IDX);
    // Only a word that completes a vector needs FIFO space; discarded tail words never stall.
    assign w_commit_word = !r_drop && (bus.s_last || w_at_end);
    assign w_ready       = rst && (!w_full || !w_commit_word);
    assign w_acc         = bus.s_valid && w_ready;
    assign w_push        = w_acc && w_commit_word;
    assign w_short       = w_push && bus.s_last && !w_at_end;
    assign w_long        = w_push && !bus.s_last && w_at_end;
    assign w_pop         = (r_state == ST_IDLE) && bus.fetch_pkt_fea && (w_level != '0);

    // Lanes past the current word are still zero from the previous commit, so short packets pad for free.
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_lane
        assign w_push_vec[k] = (r_word_cnt == CW'(k)) ? bus.s_data : r_asm[k];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= '0;
            r_drop     <= 1'b0;
            r_asm      <= '0;
        end else if (w_acc) begin
            if (r_drop) begin
                if (bus.s_last) r_drop <= 1'b0;
            end else if (w_push) begin
                r_word_cnt <= '0;
                r_asm      <= '0;
                r_drop     <= w_long;
            end else begin
                r_asm[r_word_cnt] <= bus.s_data;
                r_word_cnt        <= r_word_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= w_push_vec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_short || w_long) r_err <= 1'b1;
        end
    end

    // WAIT_LOW swallows the controller's request lingering past the pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_rptr    <= '0;
            r_pkt_fea <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_pkt_fea <= r_mem[r_rptr[AW-1:0]];
                        r_rptr    <= r_rptr + PW'(1);
                        r_state   <= ST_PRESENT;
                    end
                end
                ST_PRESENT:  r_state <= ST_WAIT_LOW;
                ST_WAIT_LOW: if (!bus.fetch_pkt_fea) r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FEA_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_drop_cnt <= '0;
        else if ((w_short || w_long) && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign bus.drop_cnt = r_drop_cnt;
`else
    assign bus.drop_cnt = '0;
`endif

    assign bus.s_ready       = w_ready;
    assign bus.pkt_fea_valid = (r_state == ST_PRESENT);
    assign bus.pkt_fea       = r_pkt_fea;
    assign bus.fea_err       = r_err;
    assign bus.fifo_level    = w_level;
endmodule

// File: tb/tb_vpe_fea_feeder.sv
// Randomized bench for vpe_fea_feeder: packet-list reference model plus served-vector scoreboard.
module tb_vpe_fea_feeder;
    localparam int DATA_W    = 8;
    localparam int NUM_WORDS = 16;
    localparam int DEPTH     = 4;
    localparam int VW        = NUM_WORDS * DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vpe_fea_feeder_if #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .DEPTH(DEPTH)) bus();

    vpe_fea_feeder #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .DEPTH(DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_bad = 0;
    int n_pulse = 0;
    int last_wait = 0;
    bit gap_en = 1'b0;

    // Reference model: a packet is a list of words; a vector is its first NUM_WORDS words, zero padded.
    logic [VW-1:0]     exp_q [$];
    logic [DATA_W-1:0] cur [$];
    bit                mdl_drop = 1'b0;
    bit                mdl_err = 1'b0;
    int                mdl_drops = 0;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_dc();
`ifdef FEA_DROP_CNT_EN
        return (mdl_drops > 65535) ? 16'hFFFF : mdl_drops[15:0];
`else
        return 16'h0;
`endif
    endfunction

    function automatic void mdl_word(input logic [DATA_W-1:0] d, input logic last);
        logic [VW-1:0] v;
        if (mdl_drop) begin
            if (last) mdl_drop = 1'b0;
            return;
        end
        cur.push_back(d);
        if (last || cur.size() == NUM_WORDS) begin
            v = '0;
            foreach (cur[k]) v[k*DATA_W +: DATA_W] = cur[k];
            exp_q.push_back(v);
            if (cur.size() != NUM_WORDS || !last) begin
                mdl_err = 1'b1;
                mdl_drops++;
            end
            if (!last) mdl_drop = 1'b1;
            cur.delete();
        end
    endfunction

    function automatic void mdl_reset();
        exp_q.delete();
        cur.delete();
        mdl_drop  = 1'b0;
        mdl_err   = 1'b0;
        mdl_drops = 0;
    endfunction

    // Scoreboard: every pulse must present the oldest committed vector.
    always @(negedge clk) begin
        if (rst && bus.pkt_fea_valid) begin
            n_pulse++;
            if (exp_q.size() == 0) chk("spurious_pulse", VW'(exp_q.size()), VW'(1));
            else chk("vec", bus.pkt_fea, exp_q.pop_front());
        end
    end

    // Called just after a posedge; returns just after the posedge that accepted the word.
    task automatic drive_word(input logic [DATA_W-1:0] d, input logic last);
        int w;
        if (gap_en) begin
            repeat ($urandom_range(0, 1)) begin
                bus.s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        w = 0;
        @(negedge clk);
        while (!bus.s_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        last_wait = w;
        if (!bus.s_ready) begin
            chk("rdy_timeout", VW'(bus.s_ready), VW'(1));
            bus.s_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        mdl_word(d, last);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_pkt(input int len);
        for (int i = 0; i < len; i++) drive_word(DATA_W'($urandom), (i == len - 1));
    endtask

    task automatic fetch_one(input int hold);
        int p0;
        int w;
        p0 = n_pulse;
        w  = 0;
        bus.fetch_pkt_fea = 1'b1;
        @(posedge clk);
        while (n_pulse == p0 && w < 200) begin
            w++;
            @(posedge clk);
        end
        repeat (hold) @(posedge clk);
        #1 bus.fetch_pkt_fea = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("one_pulse", VW'(n_pulse - p0), VW'(1));
    endtask

    task automatic chk_state(input string tag);
        @(negedge clk);
        chk({tag, "_lvl"},  VW'(bus.fifo_level), VW'(exp_q.size()));
        chk({tag, "_err"},  VW'(bus.fea_err),    VW'(mdl_err));
        chk({tag, "_drop"}, VW'(bus.drop_cnt),   VW'(exp_dc()));
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},  VW'(bus.s_ready),       VW'(0));
        chk({tag, "_vld"},  VW'(bus.pkt_fea_valid), VW'(0));
        chk({tag, "_fea"},  bus.pkt_fea,            VW'(0));
        chk({tag, "_err"},  VW'(bus.fea_err),       VW'(0));
        chk({tag, "_drop"}, VW'(bus.drop_cnt),      VW'(0));
        chk({tag, "_lvl"},  VW'(bus.fifo_level),    VW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d16;
        int p0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.fetch_pkt_fea = 1'b0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", VW'(bus.s_ready), VW'(1));
        @(posedge clk); #1;

        // Basic ordered packet 0x01..0x10
        for (int i = 1; i <= 16; i++) drive_word(DATA_W'(i), (i == 16));
        chk_state("basic_pre");
        fetch_one(1);
        chk("basic_b0",  VW'(bus.pkt_fea[7:0]),     VW'(8'h01));
        chk("basic_b15", VW'(bus.pkt_fea[127:120]), VW'(8'h10));
        chk_state("basic_post");

        // Held fetch with two buffered vectors
        send_pkt(16);
        send_pkt(16);
        fetch_one(3);
        chk_state("held1");
        fetch_one(0);
        chk_state("held2");

        // Full FIFO: the commit word of packet 5 stalls until one fetch
        for (int i = 0; i < DEPTH; i++) send_pkt(16);
        chk_state("full4");
        for (int i = 0; i < 15; i++) begin
            drive_word(DATA_W'($urandom), 1'b0);
            chk("full_nostall", VW'(last_wait), VW'(0));
        end
        d16 = DATA_W'($urandom);
        bus.s_valid = 1'b1;
        bus.s_data  = d16;
        bus.s_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_stall", VW'(bus.s_ready), VW'(0));
        end
        @(posedge clk); #1;
        fork
            drive_word(d16, 1'b1);
            fetch_one(0);
        join
        chk_state("full5");
        while (exp_q.size() > 0) fetch_one(0);
        chk_state("full_drain");

        // Short then long packet
        drive_word(8'hAA, 1'b0);
        drive_word(8'hBB, 1'b0);
        drive_word(8'hCC, 1'b1);
        fetch_one(0);
        chk("short_lo", VW'(bus.pkt_fea[23:0]), VW'(24'hCCBBAA));
        chk("short_hi", VW'(bus.pkt_fea[VW-1:24]), VW'(0));
        chk_state("short");
        send_pkt(20);
        send_pkt(16);
        chk_state("long");
        fetch_one(0);
        fetch_one(0);
        chk_state("long_drain");

        // Fetch on empty, then a packet arrives while fetch stays high
        bus.fetch_pkt_fea = 1'b1;
        p0 = n_pulse;
        repeat (10) @(posedge clk);
        #1;
        chk("empty_nopulse", VW'(n_pulse - p0), VW'(0));
        send_pkt(16);
        @(negedge clk);
        chk("empty_lvl1", VW'(bus.fifo_level), VW'(1));
        chk("empty_vld0", VW'(bus.pkt_fea_valid), VW'(0));
        @(negedge clk);
        chk("empty_vld1", VW'(bus.pkt_fea_valid), VW'(1));
        @(posedge clk); #1 bus.fetch_pkt_fea = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("empty_pulses", VW'(n_pulse - p0), VW'(1));
        chk_state("empty_done");

        // Randomized traffic with gaps, random lengths and random fetch timing
        gap_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if (exp_q.size() == DEPTH || (exp_q.size() > 0 && $urandom_range(0, 2) == 0))
                fetch_one($urandom_range(0, 2));
            send_pkt(($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 16);
            chk_state("rnd");
        end
        while (exp_q.size() > 0) fetch_one(0);
        chk_state("rnd_drain");
        gap_en = 1'b0;

        // Reset mid-packet with one vector buffered
        send_pkt(16);
        for (int i = 0; i < 7; i++) drive_word(DATA_W'($urandom), 1'b0);
        #2 rst = 1'b0;
        mdl_reset();
        @(negedge clk);
        chk_reset_vals("midrst");
        @(posedge clk); #1 rst = 1'b1;
        send_pkt(16);
        chk_state("post_rst");
        fetch_one(0);
        chk_state("post_rst_drain");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
